// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   MAX_STAGES : deepest supported pipeline
//   mode_e     : encoding of the add/subtract mode input
//   clog2      : ceiling log2 helper
//   seg_w      : width of one pipeline segment (WIDTH / STAGES)
package cla_pkg;

    localparam int MAX_STAGES = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int seg_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational carry-lookahead segment.
//   a, b   : SEG_W-bit operand slices
//   c_in   : segment carry-in
//   s      : SEG_W-bit sum
//   c_out  : carry out of the segment MSB
//   c_msb  : carry into the segment MSB (used for signed overflow)
// Level 1 forms bit P/G and flat group P/G; level 2 derives every group
// carry directly from c_in and the group P/G, so no carry ripples between
// groups. Bit carries inside a group are likewise flat products.
module cla_segment #(
    parameter int SEG_W = 16,
    parameter int GROUP = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             c_in,
    output logic [SEG_W-1:0] s,
    output logic             c_out,
    output logic             c_msb
);

    localparam int NG = SEG_W / GROUP;

    logic [SEG_W-1:0] p;
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] c;
    logic [NG-1:0]    bp;
    logic [NG-1:0]    bg;
    logic [NG:0]      cg;

    assign p     = a ^ b;
    assign g     = a & b;
    assign cg[0] = c_in;

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_group
            localparam int BASE = gi * GROUP;

            logic             grp_p;
            logic             grp_g;
            logic             grp_cout;
            logic [GROUP-1:0] bit_c;

            // Group propagate/generate as a sum of products.
            always_comb begin
                logic term;
                grp_p = &p[BASE +: GROUP];
                grp_g = 1'b0;
                for (int i = 0; i < GROUP; i++) begin
                    term = g[BASE + i];
                    for (int k = i + 1; k < GROUP; k++) begin
                        term = term & p[BASE + k];
                    end
                    grp_g = grp_g | term;
                end
            end

            assign bp[gi] = grp_p;
            assign bg[gi] = grp_g;

            // Carry out of this group, straight from the segment carry-in.
            always_comb begin
                logic term;
                grp_cout = c_in;
                for (int k = 0; k <= gi; k++) begin
                    grp_cout = grp_cout & bp[k];
                end
                for (int m = 0; m <= gi; m++) begin
                    term = bg[m];
                    for (int k = m + 1; k <= gi; k++) begin
                        term = term & bp[k];
                    end
                    grp_cout = grp_cout | term;
                end
            end

            assign cg[gi+1] = grp_cout;

            // Carries into each bit of the group from the group carry-in.
            always_comb begin
                logic term;
                logic carry;
                bit_c = '0;
                for (int i = 0; i < GROUP; i++) begin
                    carry = cg[gi];
                    for (int k = 0; k < i; k++) begin
                        carry = carry & p[BASE + k];
                    end
                    for (int m = 0; m < i; m++) begin
                        term = g[BASE + m];
                        for (int k = m + 1; k < i; k++) begin
                            term = term & p[BASE + k];
                        end
                        carry = carry | term;
                    end
                    bit_c[i] = carry;
                end
            end

            assign c[BASE +: GROUP] = bit_c;
        end
    endgenerate

    assign s     = p ^ c;
    assign c_out = cg[NG];
    assign c_msb = c[SEG_W-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Parametrised pipelined carry-lookahead adder/subtractor with an elastic
// valid/ready pipeline.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake
//   a, b, c_in, sub      : operands, carry-in (ignored when sub=1), mode
//   out_valid / out_ready: result handshake
//   s, c_out, ovf, zero  : result, MSB carry-out, signed overflow, s==0
// Stage k adds bits [k*SEG +: SEG] using the carry registered by stage k-1.
// Each stage register holds the lower sum bits already produced together
// with the upper operand A bits (one shared data word), the upper operand B
// bits and the running carry. The last stage also forms the flags.
// Optional build macro CLA_PIPE_SAT_EN: signed saturation of s on overflow.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG  = seg_w(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if ((WIDTH % (STAGES * GROUP)) != 0 || STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_params
        $error("cla_pipe_addsub: illegal WIDTH=%0d GROUP=%0d STAGES=%0d", WIDTH, GROUP, STAGES);
    end

    logic [WIDTH-1:0] stage_data  [STAGES];
    logic [WIDTH-1:0] stage_b     [STAGES];
    logic             stage_carry [STAGES];
    logic             stage_valid [STAGES];
    logic [STAGES:0]  ready_chain;
    logic             ovf_reg;
    logic             zero_reg;
    mode_e            sub_mode;

    assign sub_mode            = mode_e'(sub);
    assign ready_chain[STAGES] = out_ready;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            // Operand B bits that later stages still need.
            localparam logic [WIDTH-1:0] HI_MASK = {WIDTH{1'b1}} << ((gi + 1) * SEG);

            logic [WIDTH-1:0] d_in;
            logic [WIDTH-1:0] b_in;
            logic             c_in_k;
            logic             v_in;
            logic [SEG-1:0]   seg_sum;
            logic             seg_co;
            logic             seg_cmsb;
            logic [WIDTH-1:0] d_out;
            logic [WIDTH-1:0] d_load;
            logic [WIDTH-1:0] data_reg;
            logic             carry_reg;
            logic             valid_reg;

            // A stage accepts when empty or when its beat moves on this cycle;
            // the chain only depends on registered valids and out_ready.
            assign ready_chain[gi] = !valid_reg || ready_chain[gi+1];

            if (gi == 0) begin : g_src_in
                // Subtraction folds into stage 0; later stages never see the mode.
                assign d_in   = a;
                assign b_in   = (sub_mode == MODE_SUB) ? ~b : b;
                assign c_in_k = (sub_mode == MODE_SUB) ? 1'b1 : c_in;
                assign v_in   = in_valid;
            end else begin : g_src_reg
                assign d_in   = stage_data[gi-1];
                assign b_in   = stage_b[gi-1];
                assign c_in_k = stage_carry[gi-1];
                assign v_in   = stage_valid[gi-1];
            end

            cla_segment #(
                .SEG_W (SEG),
                .GROUP (GROUP)
            ) u_seg (
                .a     (d_in[gi*SEG +: SEG]),
                .b     (b_in[gi*SEG +: SEG]),
                .c_in  (c_in_k),
                .s     (seg_sum),
                .c_out (seg_co),
                .c_msb (seg_cmsb)
            );

            always_comb begin
                d_out                 = d_in;
                d_out[gi*SEG +: SEG]  = seg_sum;
            end

            if (gi == LAST) begin : g_last
                logic ovf_raw;

                assign ovf_raw = seg_cmsb ^ seg_co;

                // d_in[WIDTH-1] is still the untouched sign of operand A here.
`ifdef CLA_PIPE_SAT_EN
                always_comb begin
                    d_load = d_out;
                    if (ovf_raw) begin
                        d_load = d_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
                    end
                end
`else
                assign d_load = d_out;
`endif

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_reg  <= 1'b0;
                        zero_reg <= 1'b0;
                    end else if (ready_chain[gi] && v_in) begin
                        ovf_reg  <= ovf_raw;
                        zero_reg <= (d_load == '0);
                    end
                end

                assign stage_b[gi] = '0;
            end else begin : g_mid
                logic [WIDTH-1:0] b_reg;

                assign d_load = d_out;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        b_reg <= '0;
                    end else if (ready_chain[gi] && v_in) begin
                        b_reg <= b_in & HI_MASK;
                    end
                end

                assign stage_b[gi] = b_reg;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                    carry_reg <= 1'b0;
                end else if (ready_chain[gi]) begin
                    valid_reg <= v_in;
                    // Payload only moves with a real beat, so a held or
                    // emptied last stage keeps s stable.
                    if (v_in) begin
                        data_reg  <= d_load;
                        carry_reg <= seg_co;
                    end
                end
            end

            assign stage_data[gi]  = data_reg;
            assign stage_carry[gi] = carry_reg;
            assign stage_valid[gi] = valid_reg;
        end
    endgenerate

    assign in_ready  = ready_chain[0];
    assign out_valid = stage_valid[LAST];
    assign s         = stage_data[LAST];
    assign c_out     = stage_carry[LAST];
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

endmodule
